lock_watchdog: RTL and testbench
================================

# lock_watchdog

Supervises a feedback lock by driving the hold input of an external timeout counter and consuming its overflow flag. It sits beside a PID/lock path, one watchdog per lock. When the lock-quality indicator stays false for a full timeout, it raises a relock request to the lock-acquisition logic and waits for the acknowledge. It then runs the counter again as a settle timer and either declares the lock recovered or counts a failed attempt, up to a programmable retry limit.

## Interface
- MAXRW, 8: width of retry limit and retry count.
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  1 = supervise; 0 = return to IDLE.
- in_range_i  in  1  lock-quality indicator, 1 = error signal within window.
- overflow_i  in  1  from timeout counter; sticky 1 once count reaches its limit; cleared by hold.
- hold_o  out  1  to timeout counter; 1 = counter cleared and held, 0 = counting.
- max_retries_i  in  MAXRW  number of relock attempts allowed before FAILED.
- relock_req_o  out  1  level request to acquisition logic.
- relock_ack_i  in  1  acknowledge from acquisition logic.
- locked_o  out  1  1 in LOCKED only.
- failed_o  out  1  1 in FAILED only.
- retry_cnt_o  out  MAXRW  attempts made since last successful lock.
- state_o  out  3  state code, for status registers.

## Operation
- Moore FSM. All outputs are registered and decoded from the state/count registers.
- State codes: IDLE=0, LOCKED=1, TIMING=2, RELOCK=3, SETTLE=4, FAILED=5.
- Output decode:
  - hold_o = 0 only in TIMING and SETTLE.
  - relock_req_o = 1 only in RELOCK.
- enable_i=0 in any state: next state IDLE and retry_cnt cleared. This has priority over every other transition.
- IDLE: if enable_i=1, go to LOCKED when in_range_i=1, else to TIMING.
- LOCKED: in_range_i=0 -> TIMING.
- TIMING:
  - in_range_i=1 -> LOCKED. This wins over a simultaneous overflow.
  - Otherwise overflow_i=1 (not in blanking cycle) -> attempt.
- Attempt rule:
  - If retry_cnt == max_retries_i -> FAILED.
  - Else retry_cnt+1 and go to RELOCK.
- RELOCK: wait for relock_ack_i=1 -> SETTLE. relock_req_o drops with the state change; the ack is level and is ignored elsewhere.
- SETTLE: on overflow_i=1 (not in blanking cycle):
  - in_range_i=1 -> LOCKED with retry_cnt cleared.
  - in_range_i=0 -> attempt rule.
- FAILED: absorbing. Exit only via enable_i=0 or reset.
- Blanking: overflow_i is ignored in the first cycle of TIMING and of SETTLE, while the counter is leaving hold.
- Every entry into TIMING or SETTLE is preceded by at least one cycle with hold_o=1.
- retry_cnt saturates at 2^MAXRW-1 and never wraps.
- max_retries_i=0: the first timeout in TIMING goes directly to FAILED, with no relock request.
- max_retries_i is sampled at each comparison; changes take effect at the next attempt.

## Timing
- Reset (async assert, sync release): state IDLE, hold_o=1, relock_req_o=0, locked_o=0, failed_o=0, retry_cnt_o=0, state_o=0.
- Input latency: an input sampled at edge t changes state and outputs visible after edge t (one cycle).
  - in_range_i falling -> hold_o low 1 cycle later.
  - Counter with limit N: overflow_i seen about N+1 cycles after that.
  - overflow_i -> relock_req_o high 1 cycle later.
  - relock_ack_i -> relock_req_o low and hold_o low 1 cycle later.
- Minimum RELOCK dwell: 1 cycle (ack already high on entry).
- Reset mid-RELOCK: relock_req_o drops asynchronously; acquisition logic must tolerate a withdrawn request.

## Test plan
- Reset and arm: rst_i pulse, enable_i=1, in_range_i=1 -> state_o=1, locked_o=1, hold_o=1, others 0.
- Glitch tolerance: in_range_i low for 5 cycles, overflow_i held 0 -> TIMING for 5 cycles, hold_o=0, then LOCKED. No request; retry_cnt_o=0.
- Recovery: max_retries_i=3, in_range_i low, overflow_i=1 -> RELOCK, relock_req_o=1, retry_cnt_o=1.
  - Ack after 4 cycles -> SETTLE.
  - Overflow with in_range_i=1 -> LOCKED, retry_cnt_o=0.
- Exhaustion: max_retries_i=2, every settle ends out of range -> two requests, then FAILED.
  - failed_o=1, retry_cnt_o=2.
  - enable_i=0 -> IDLE, failed_o=0, retry_cnt_o=0.
- Boundaries:
  - max_retries_i=0: timeout -> FAILED, relock_req_o never asserted.
  - overflow_i and in_range_i both 1 in TIMING -> LOCKED.
  - overflow_i=1 on first TIMING cycle -> ignored.
- Async reset in RELOCK mid-request -> relock_req_o=0 and hold_o=1 before the next clock edge.

Source files
------------

// File: rtl/lock_watchdog.sv
// rtl/lock_watchdog.sv - lock supervisor driving an external timeout counter and relock handshake
//
// Purpose:
//   Watches a lock-quality indicator. A full timeout out of range raises a
//   relock request; after the acknowledge the same external counter acts as a
//   settle timer. A settle ending in range recovers the lock; otherwise the
//   attempt is counted, up to max_retries_i, after which the block is FAILED.
//
// Ports:
//   clk_i          in   system clock, rising edge
//   rst_i          in   asynchronous active-high reset
//   enable_i       in   1 = supervise, 0 = force IDLE and clear retry count
//   in_range_i     in   lock-quality indicator
//   overflow_i     in   sticky overflow from the external timeout counter
//   hold_o         out  1 = hold/clear the external counter
//   max_retries_i  in   relock attempts allowed before FAILED
//   relock_req_o   out  level relock request (RELOCK only)
//   relock_ack_i   in   relock acknowledge
//   locked_o       out  1 in LOCKED only
//   failed_o       out  1 in FAILED only
//   retry_cnt_o    out  attempts since last successful lock
//   state_o        out  state code

module lock_watchdog #(
    parameter int MAXRW = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             in_range_i,
    input  logic             overflow_i,
    output logic             hold_o,
    input  logic [MAXRW-1:0] max_retries_i,
    output logic             relock_req_o,
    input  logic             relock_ack_i,
    output logic             locked_o,
    output logic             failed_o,
    output logic [MAXRW-1:0] retry_cnt_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOCKED = 3'd1,
        ST_TIMING = 3'd2,
        ST_RELOCK = 3'd3,
        ST_SETTLE = 3'd4,
        ST_FAILED = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [MAXRW-1:0] r_retry_cnt;
    logic [MAXRW-1:0] w_retry_next;
    // High during the first cycle of TIMING/SETTLE, while the counter is
    // still leaving hold and its overflow flag may be stale.
    logic             r_blank;
    logic             w_blank_next;
    logic             w_ovf_valid;
    logic             w_counting_next;

    logic             r_hold;
    logic             r_relock_req;
    logic             r_locked;
    logic             r_failed;

    assign w_ovf_valid = overflow_i && !r_blank;

    always_comb begin
        w_state_next = r_state;
        w_retry_next = r_retry_cnt;

        if (!enable_i) begin
            w_state_next = ST_IDLE;
            w_retry_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = in_range_i ? ST_LOCKED : ST_TIMING;
                end
                ST_LOCKED: begin
                    if (!in_range_i) begin
                        w_state_next = ST_TIMING;
                    end
                end
                ST_TIMING: begin
                    if (in_range_i) begin
                        w_state_next = ST_LOCKED;
                    end else if (w_ovf_valid) begin
                        if (r_retry_cnt == max_retries_i) begin
                            w_state_next = ST_FAILED;
                        end else begin
                            w_state_next = ST_RELOCK;
                            if (r_retry_cnt != '1) begin
                                w_retry_next = r_retry_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_RELOCK: begin
                    if (relock_ack_i) begin
                        w_state_next = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_ovf_valid) begin
                        if (in_range_i) begin
                            w_state_next = ST_LOCKED;
                            w_retry_next = '0;
                        end else if (r_retry_cnt == max_retries_i) begin
                            w_state_next = ST_FAILED;
                        end else begin
                            w_state_next = ST_RELOCK;
                            if (r_retry_cnt != '1) begin
                                w_retry_next = r_retry_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_FAILED: begin
                    w_state_next = ST_FAILED;
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_retry_next = '0;
                end
            endcase
        end
    end

    // TIMING and SETTLE are only entered from states that hold the counter,
    // so the counter always starts from a cleared value.
    assign w_counting_next = (w_state_next == ST_TIMING) || (w_state_next == ST_SETTLE);
    assign w_blank_next    = w_counting_next && (w_state_next != r_state);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_retry_cnt  <= '0;
            r_blank      <= 1'b0;
            r_hold       <= 1'b1;
            r_relock_req <= 1'b0;
            r_locked     <= 1'b0;
            r_failed     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_retry_cnt  <= w_retry_next;
            r_blank      <= w_blank_next;
            r_hold       <= !w_counting_next;
            r_relock_req <= (w_state_next == ST_RELOCK);
            r_locked     <= (w_state_next == ST_LOCKED);
            r_failed     <= (w_state_next == ST_FAILED);
        end
    end

    assign hold_o       = r_hold;
    assign relock_req_o = r_relock_req;
    assign locked_o     = r_locked;
    assign failed_o     = r_failed;
    assign retry_cnt_o  = r_retry_cnt;
    assign state_o      = r_state;

endmodule

// File: tb/tb_lock_watchdog.sv
// tb/tb_lock_watchdog.sv - scoreboard bench for lock_watchdog
module tb_lock_watchdog;

    localparam int MAXRW = 8;
    localparam int VW    = 3 + 4 + MAXRW;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             enable_i;
    logic             in_range_i;
    logic             overflow_i;
    logic             hold_o;
    logic [MAXRW-1:0] max_retries_i;
    logic             relock_req_o;
    logic             relock_ack_i;
    logic             locked_o;
    logic             failed_o;
    logic [MAXRW-1:0] retry_cnt_o;
    logic [2:0]       state_o;

    lock_watchdog #(.MAXRW(MAXRW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .in_range_i   (in_range_i),
        .overflow_i   (overflow_i),
        .hold_o       (hold_o),
        .max_retries_i(max_retries_i),
        .relock_req_o (relock_req_o),
        .relock_ack_i (relock_ack_i),
        .locked_o     (locked_o),
        .failed_o     (failed_o),
        .retry_cnt_o  (retry_cnt_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [VW-1:0] exp_q[$];

    // reference model state
    int            m_state;
    int            m_cnt;
    bit            m_blank;

    bit            req_seen;
    always @(posedge clk) if (relock_req_o) req_seen <= 1'b1;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [VW-1:0] pack_exp(input int st, input int cnt);
        logic [VW-1:0] v;
        v = '0;
        v[VW-1 -: 3]   = st[2:0];
        v[MAXRW+3]     = !(st == 2 || st == 4);
        v[MAXRW+2]     = (st == 3);
        v[MAXRW+1]     = (st == 1);
        v[MAXRW]       = (st == 5);
        v[MAXRW-1:0]   = cnt[MAXRW-1:0];
        return v;
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {state_o, hold_o, relock_req_o, locked_o, failed_o, retry_cnt_o};
    endfunction

    function automatic logic [VW-1:0] bit_val(input logic b);
        logic [VW-1:0] v;
        v = '0;
        v[0] = b;
        return v;
    endfunction

    // one failed relock attempt, or FAILED when the budget is spent
    task automatic model_attempt(output int ns);
        if (m_cnt == int'(max_retries_i)) ns = 5;
        else begin
            ns = 3;
            if (m_cnt < (1 << MAXRW) - 1) m_cnt = m_cnt + 1;
        end
    endtask

    // Drives one cycle of inputs, predicts the outputs after the next edge,
    // then compares them one time unit after that edge.
    task automatic cyc(input string tag, input bit en, input bit inr, input bit ovf, input bit ack);
        int  ns;
        bit  ov;
        enable_i     = en;
        in_range_i   = inr;
        overflow_i   = ovf;
        relock_ack_i = ack;
        ov = ovf && !m_blank;
        ns = m_state;
        if (!en) begin
            ns = 0;
            m_cnt = 0;
        end else begin
            if (m_state == 0) ns = inr ? 1 : 2;
            else if (m_state == 1) begin
                if (!inr) ns = 2;
            end else if (m_state == 2) begin
                if (inr) ns = 1;
                else if (ov) model_attempt(ns);
            end else if (m_state == 3) begin
                if (ack) ns = 4;
            end else if (m_state == 4) begin
                if (ov) begin
                    if (inr) begin
                        ns = 1;
                        m_cnt = 0;
                    end else model_attempt(ns);
                end
            end
        end
        m_blank = (ns == 2 || ns == 4) && (ns != m_state);
        m_state = ns;
        exp_q.push_back(pack_exp(m_state, m_cnt));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) chk({tag, "_empty"}, '0, '1);
        else chk(tag, dut_vec(), exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_blank = 0;
        exp_q.delete();
    endtask

    initial begin
        rst_i         = 1'b1;
        enable_i      = 1'b0;
        in_range_i    = 1'b0;
        overflow_i    = 1'b0;
        relock_ack_i  = 1'b0;
        max_retries_i = 8'd3;
        req_seen      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset", dut_vec(), pack_exp(0, 0));
        rst_i = 1'b0;

        // arm
        cyc("arm", 1, 1, 0, 0);
        chk("arm_locked", bit_val(locked_o), bit_val(1'b1));

        // glitch: 5 cycles out of range, counter never overflows
        for (int i = 0; i < 5; i++) cyc("glitch_timing", 1, 0, 0, 0);
        chk("glitch_hold", bit_val(hold_o), bit_val(1'b0));
        cyc("glitch_back", 1, 1, 0, 0);
        chk("glitch_cnt", retry_cnt_o, '0);

        // recovery, with overflow already set on the blanked first TIMING cycle
        max_retries_i = 8'd3;
        cyc("rec_enter", 1, 0, 0, 0);
        cyc("rec_blank_ovf", 1, 0, 1, 0);
        chk("blank_ignored", state_o, 3'd2);
        cyc("rec_timeout", 1, 0, 1, 0);
        chk("rec_req", bit_val(relock_req_o), bit_val(1'b1));
        chk("rec_cnt1", retry_cnt_o, 8'd1);
        for (int i = 0; i < 4; i++) cyc("rec_wait", 1, 0, 0, 0);
        cyc("rec_ack", 1, 0, 0, 1);
        chk("rec_settle", state_o, 3'd4);
        cyc("rec_settle_blank", 1, 1, 1, 1);
        cyc("rec_settle_done", 1, 1, 1, 0);
        chk("rec_cnt0", retry_cnt_o, '0);

        // in_range wins over overflow in TIMING
        cyc("both_enter", 1, 0, 0, 0);
        cyc("both_blank", 1, 0, 0, 0);
        cyc("both_hit", 1, 1, 1, 0);
        chk("both_locked", state_o, 3'd1);

        // exhaustion with max_retries = 2
        max_retries_i = 8'd2;
        cyc("exh_enter", 1, 0, 0, 0);
        cyc("exh_blank", 1, 0, 0, 0);
        cyc("exh_to1", 1, 0, 1, 0);
        for (int a = 0; a < 2; a++) begin
            cyc("exh_ack", 1, 0, 0, 1);
            cyc("exh_sblank", 1, 0, 1, 0);
            cyc("exh_sovf", 1, 0, 1, 0);
        end
        chk("exh_failed", bit_val(failed_o), bit_val(1'b1));
        chk("exh_cnt", retry_cnt_o, 8'd2);
        cyc("exh_absorb", 1, 1, 1, 1);
        cyc("exh_disable", 0, 1, 0, 0);
        chk("exh_idle_cnt", retry_cnt_o, '0);

        // max_retries = 0 goes straight to FAILED
        max_retries_i = 8'd0;
        req_seen = 1'b0;
        cyc("z_enter", 1, 0, 0, 0);
        cyc("z_blank", 1, 0, 1, 0);
        cyc("z_timeout", 1, 0, 1, 0);
        chk("z_failed", state_o, 3'd5);
        chk("z_no_req", bit_val(req_seen), bit_val(1'b0));
        cyc("z_disable", 0, 0, 0, 0);

        // saturation-free random walk with random inputs, model-checked
        max_retries_i = 8'd4;
        for (int i = 0; i < 60; i++)
            cyc("rand", ($urandom_range(0, 15) != 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        cyc("rand_off", 0, 0, 0, 0);

        // async reset while requesting
        max_retries_i = 8'd3;
        cyc("ar_enter", 1, 0, 0, 0);
        cyc("ar_blank", 1, 0, 0, 0);
        cyc("ar_relock", 1, 0, 1, 0);
        chk("ar_req_on", bit_val(relock_req_o), bit_val(1'b1));
        #2;
        rst_i = 1'b1;
        #1;
        chk("ar_req_off", bit_val(relock_req_o), bit_val(1'b0));
        chk("ar_hold_on", bit_val(hold_o), bit_val(1'b1));
        chk("ar_vec", dut_vec(), pack_exp(0, 0));
        model_reset();
        @(negedge clk);
        rst_i = 1'b0;
        cyc("ar_rearm", 1, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
